// File: rtl/hlsm_launcher.sv
// Host-side launcher for an HLSM core: command intake, Start/Done sequencing, result FIFO.
// Optional watchdog enabled by defining HLSM_LAUNCHER_TIMEOUT_EN.
module hlsm_launcher #(
  parameter int DATAW   = 65,
  parameter int RDEPTH  = 4,
  parameter int TMO_CYC = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DATAW-1:0] cmd_a,
  input  logic [DATAW-1:0] cmd_b,
  input  logic [DATAW-1:0] cmd_c,
  input  logic [DATAW-1:0] cmd_d,
  input  logic [DATAW-1:0] cmd_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DATAW-1:0] res_z,
  output logic             res_err,
  output logic             core_start,
  output logic [DATAW-1:0] core_a,
  output logic [DATAW-1:0] core_b,
  output logic [DATAW-1:0] core_c,
  output logic [DATAW-1:0] core_d,
  output logic [DATAW-1:0] core_zero,
  input  logic             core_done,
  input  logic [DATAW-1:0] core_z,
  output logic             busy,
  output logic [15:0]      op_cnt
);

  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [15:0]      opcnt_q, opcnt_d;
  logic [DATAW-1:0] a_q, b_q, c_q, d_q, zero_q;

  logic [DATAW-1:0] mem_z_q [RDEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    fcnt_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic [DATAW-1:0] push_z;

`ifdef HLSM_LAUNCHER_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic          mem_e_q [RDEPTH];
  logic          push_err;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TMO_CYC - 1));
`endif

  assign cmd_ready  = (state_q == IDLE) && (fcnt_q < CW'(RDEPTH));
  assign accept     = cmd_valid && cmd_ready;
  assign res_valid  = (fcnt_q != '0);
  assign pop        = res_ready && res_valid;
  assign res_z      = res_valid ? mem_z_q[rptr_q] : '0;
  assign core_start = start_q;
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_c     = c_q;
  assign core_d     = d_q;
  assign core_zero  = zero_q;
  assign busy       = (state_q != IDLE);
  assign op_cnt     = opcnt_q;

`ifdef HLSM_LAUNCHER_TIMEOUT_EN
  assign res_err = res_valid ? mem_e_q[rptr_q] : 1'b0;
`else
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    opcnt_d = opcnt_q;
    push    = 1'b0;
    push_z  = '0;
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
    push_err = 1'b0;
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ARM;
          start_d = 1'b1;
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end
      // Done is sticky from the last run; wait for the core to clear it.
      ARM: begin
        if (!core_done) begin
          state_d = RUN;
        end
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
`endif
      end
      RUN: begin
        if (core_done) begin
          push    = 1'b1;
          push_z  = core_z;
          start_d = 1'b0;
          state_d = IDLE;
          opcnt_d = opcnt_q + 16'd1;
        end
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
      end
    endcase
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
    if (tmo_hit && ((state_q == ARM) ||
                    ((state_q == RUN) && !core_done))) begin
      state_d  = IDLE;
      start_d  = 1'b0;
      push     = 1'b1;
      push_z   = '0;
      push_err = 1'b1;
      opcnt_d  = opcnt_q + 16'd1;
      tmo_d    = '0;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      opcnt_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      opcnt_q <= opcnt_d;
    end
  end

`ifdef HLSM_LAUNCHER_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      zero_q <= '0;
    end else if (accept) begin
      a_q    <= cmd_a;
      b_q    <= cmd_b;
      c_q    <= cmd_c;
      d_q    <= cmd_d;
      zero_q <= cmd_zero;
    end
  end

  // Space was reserved at accept time, so a push never meets a full FIFO.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_z_q[wptr_q] <= push_z;
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
      mem_e_q[wptr_q] <= push_err;
`endif
    end
  end

endmodule

// File: tb/tb_hlsm_launcher.sv
// Directed bench for hlsm_launcher with a behavioural 12-state HLSM core.
// Core: e=a/b, f=c/d, g=a%b; z = (g==zero) ? e : f.
module tb_hlsm_launcher;

  localparam int DW  = 65;
  localparam int TMO = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
  logic [DW-1:0] cmd_d = '0, cmd_zero = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_z;
  logic          res_err;
  logic          core_start;
  logic [DW-1:0] core_a, core_b, core_c, core_d, core_zero;
  logic          core_done;
  logic [DW-1:0] core_z;
  logic          busy;
  logic [15:0]   op_cnt;

  int total = 0;
  int bad   = 0;
  logic hang = 1'b0;

  hlsm_launcher #(
    .DATAW  (DW),
    .RDEPTH (4),
    .TMO_CYC(TMO)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .cmd_d     (cmd_d),
    .cmd_zero  (cmd_zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_err   (res_err),
    .core_start(core_start),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_c    (core_c),
    .core_d    (core_d),
    .core_zero (core_zero),
    .core_done (core_done),
    .core_z    (core_z),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  always #5 Clk = ~Clk;

  // Behavioural core: Done sticky, cleared on the first Start cycle.
  logic [3:0]    cst;
  logic          sprev, done_m;
  logic [DW-1:0] z_m, zn;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cst    <= '0;
      sprev  <= 1'b0;
      done_m <= 1'b0;
      z_m    <= '0;
      zn     <= '0;
    end else begin
      sprev <= core_start;
      if (cst == 4'd0) begin
        if (core_start && !sprev) begin
          done_m <= 1'b0;
          if (!hang) begin
            cst <= 4'd1;
            zn  <= ((core_a % core_b) == core_zero) ?
                   (core_a / core_b) : (core_c / core_d);
          end
        end
      end else if (cst == 4'd11) begin
        cst    <= 4'd0;
        done_m <= 1'b1;
        z_m    <= zn;
      end else begin
        cst <= cst + 4'd1;
      end
    end
  end

  assign core_done = done_m;
  assign core_z    = z_m;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the accept edge.
  task automatic send(input int a, input int b, input int c,
                      input int d, input int z);
    int n = 0;
    cmd_a = DW'(a); cmd_b = DW'(b); cmd_c = DW'(c);
    cmd_d = DW'(d); cmd_zero = DW'(z);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 400) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("accept_timeout", DW'(n < 400), 1);
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic start_len(output int hi);
    hi = 0;
    while (core_start && hi < 200) begin
      hi++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic pop1;
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
  endtask

  int hi;
  int ops;
  int va [5] = '{20, 20, 9, 9, 100};
  int vb [5] = '{6, 6, 4, 4, 7};
  int vc [5] = '{21, 21, 30, 30, 50};
  int vd [5] = '{3, 3, 5, 5, 2};
  int vz [5] = '{2, 0, 1, 0, 2};
  int ve [5] = '{3, 7, 2, 6, 14};

  initial begin
    ops = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_start", core_start, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_opcnt", op_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_z", res_z, 0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rdy_idle", cmd_ready, 1);

    // reset in the middle of RUN
    send(20, 6, 21, 3, 2);
    repeat (6) @(posedge Clk);
    #1;
    chk("mid_busy", busy, 1);
    Rst = 1'b0;
    #1;
    chk("mid_start_async", core_start, 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("mid_valid", res_valid, 0);
    chk("mid_opcnt", op_cnt, 0);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_core_a", core_a, 0);

    // single op, g==zero picks e
    send(20, 6, 21, 3, 2);
    chk("op1_a", core_a, 20);
    start_len(hi);
    ops++;
    chk("op1_start_len", DW'(hi), 13);
    chk("op1_valid", res_valid, 1);
    chk("op1_z", res_z, 3);
    chk("op1_err", res_err, 0);
    chk("op1_opcnt", op_cnt, DW'(ops));
    chk("op1_busy", busy, 0);
    pop1();
    chk("op1_drained", res_valid, 0);

    // stale Done from op1 must not cause early capture
    send(20, 6, 21, 3, 0);
    start_len(hi);
    ops++;
    chk("op2_start_len", DW'(hi), 13);
    chk("op2_z", res_z, 7);
    chk("op2_opcnt", op_cnt, DW'(ops));
    pop1();

    // four ops fill the FIFO with no consumer
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vc[i], vd[i], vz[i]);
      ops++;
    end
    for (int n = 0; n < 40 && busy; n++) begin
      @(posedge Clk); #1;
    end
    cmd_a = DW'(17); cmd_b = DW'(5); cmd_c = DW'(40);
    cmd_d = DW'(8); cmd_zero = DW'(0);
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 0);
    chk("full_valid", res_valid, 1);
    chk("full_opcnt", op_cnt, DW'(ops));

    // drain in order; the held fifth command slips in
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), res_valid, 1);
      chk($sformatf("drain%0d_z", i), res_z, DW'(ve[i]));
      @(posedge Clk); #1;
      if (busy) cmd_valid = 1'b0;
    end
    res_ready = 1'b0;
    chk("op5_taken", DW'(cmd_valid), 0);
    cmd_valid = 1'b0;
    for (int n = 0; n < 40 && !res_valid; n++) begin
      @(posedge Clk); #1;
    end
    ops++;
    chk("op5_z", res_z, 5);
    chk("op5_opcnt", op_cnt, DW'(ops));

    // push and pop on the same edge at count 1
    send(100, 7, 50, 2, 2);
    repeat (12) @(posedge Clk);
    #1;
    chk("pp_pre_start", core_start, 1);
    chk("pp_pre_done", core_done, 1);
    chk("pp_pre_head", res_z, 5);
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    ops++;
    chk("pp_valid", res_valid, 1);
    chk("pp_head", res_z, 14);
    chk("pp_opcnt", op_cnt, DW'(ops));
    pop1();
    chk("pp_no_dup", res_valid, 0);

    // core never finishes
    hang = 1'b1;
    send(9, 4, 30, 5, 1);
`ifdef HLSM_LAUNCHER_TIMEOUT_EN
    start_len(hi);
    ops++;
    chk("tmo_start_len", DW'(hi), TMO);
    chk("tmo_valid", res_valid, 1);
    chk("tmo_z", res_z, 0);
    chk("tmo_err", res_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_opcnt", op_cnt, DW'(ops));
`else
    repeat (100) @(posedge Clk);
    #1;
    chk("hang_start", core_start, 1);
    chk("hang_busy", busy, 1);
    chk("hang_valid", res_valid, 0);
    chk("hang_opcnt", op_cnt, DW'(ops));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
